// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_monitor
// Brief    : Passive VGA timing checker. Measures line/frame periods and sync
//            widths on pixel ticks, reports lock and sticky timing errors.
//            Define VGA_MON_CRC_EN to add a per-frame CRC-16-CCITT over rgb.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_monitor #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int CNT_W   = 12
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             pix_ce,
    input  logic [7:0]       rgb,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] h_period,
    output logic [CNT_W-1:0] h_pulse,
    output logic [CNT_W-1:0] v_period,
    output logic [CNT_W-1:0] v_pulse,
    output logic [15:0]      frame_cnt,
    output logic             frame_done,
    output logic             locked,
    output logic             err_h,
    output logic             err_v,
    output logic [15:0]      crc
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_H_TOTAL = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] c_H_SYNC  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_V_TOTAL = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] c_V_SYNC  = CNT_W'(V_SYNC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + c_ONE;
    endfunction

    logic             r_hs_prev_q,    w_hs_prev_d;
    logic             r_vs_prev_q,    w_vs_prev_d;
    logic [CNT_W-1:0] r_h_cnt_q,      w_h_cnt_d;
    logic [CNT_W-1:0] r_hp_cnt_q,     w_hp_cnt_d;
    logic [CNT_W-1:0] r_l_cnt_q,      w_l_cnt_d;
    logic [CNT_W-1:0] r_vp_cnt_q,     w_vp_cnt_d;
    logic [CNT_W-1:0] r_h_period_q,   w_h_period_d;
    logic [CNT_W-1:0] r_h_pulse_q,    w_h_pulse_d;
    logic [CNT_W-1:0] r_v_period_q,   w_v_period_d;
    logic [CNT_W-1:0] r_v_pulse_q,    w_v_pulse_d;
    logic [15:0]      r_frame_cnt_q,  w_frame_cnt_d;
    logic             r_frame_done_q, w_frame_done_d;
    logic             r_bad_line_q,   w_bad_line_d;
    logic             r_locked_q,     w_locked_d;
    logic             r_err_h_q,      w_err_h_d;
    logic             r_err_v_q,      w_err_v_d;
    state_t           r_state_q,      w_state_d;

    logic             w_h_fall, w_h_rise, w_v_fall, w_v_rise;
    logic             w_line_bad, w_bad_eval, w_frame_ok;
    logic [CNT_W-1:0] w_l_cnt_inc;

    assign w_h_fall    = r_hs_prev_q & ~hsync;
    assign w_h_rise    = ~r_hs_prev_q & hsync;
    assign w_v_fall    = r_vs_prev_q & ~vsync;
    assign w_v_rise    = ~r_vs_prev_q & vsync;

    // Line count including a coincident hsync fall on the vsync-fall tick
    assign w_l_cnt_inc = w_h_fall ? sat_inc(r_l_cnt_q) : r_l_cnt_q;
    assign w_line_bad  = (w_h_fall && (r_h_cnt_q != c_H_TOTAL)) ||
                         (w_h_rise && (r_hp_cnt_q != c_H_SYNC));
    assign w_bad_eval  = r_bad_line_q | w_line_bad;
    assign w_frame_ok  = (w_l_cnt_inc == c_V_TOTAL) && (r_v_pulse_q == c_V_SYNC);

    always_comb begin
        w_hs_prev_d    = r_hs_prev_q;
        w_vs_prev_d    = r_vs_prev_q;
        w_h_cnt_d      = r_h_cnt_q;
        w_hp_cnt_d     = r_hp_cnt_q;
        w_l_cnt_d      = r_l_cnt_q;
        w_vp_cnt_d     = r_vp_cnt_q;
        w_h_period_d   = r_h_period_q;
        w_h_pulse_d    = r_h_pulse_q;
        w_v_period_d   = r_v_period_q;
        w_v_pulse_d    = r_v_pulse_q;
        w_frame_cnt_d  = r_frame_cnt_q;
        w_frame_done_d = 1'b0;
        w_bad_line_d   = r_bad_line_q;
        w_err_h_d      = r_err_h_q;
        w_err_v_d      = r_err_v_q;
        w_state_d      = r_state_q;

        if (pix_ce) begin
            w_hs_prev_d = hsync;
            w_vs_prev_d = vsync;

            if (w_h_fall) begin
                w_h_period_d = r_h_cnt_q;
                w_h_cnt_d    = c_ONE;
            end else begin
                w_h_cnt_d    = sat_inc(r_h_cnt_q);
            end

            if (w_h_rise) begin
                w_h_pulse_d = r_hp_cnt_q;
                w_hp_cnt_d  = '0;
            end else if (!hsync) begin
                w_hp_cnt_d  = sat_inc(r_hp_cnt_q);
            end

            if (w_v_rise) begin
                w_v_pulse_d = r_vp_cnt_q;
                w_vp_cnt_d  = '0;
            end else if (!vsync && w_h_fall) begin
                w_vp_cnt_d  = sat_inc(r_vp_cnt_q);
            end

            if (w_v_fall) begin
                w_v_period_d   = w_l_cnt_inc;
                w_l_cnt_d      = '0;
                w_frame_cnt_d  = r_frame_cnt_q + 16'd1;
                w_frame_done_d = 1'b1;
                w_bad_line_d   = 1'b0;
                case (r_state_q)
                    SEARCH:  w_state_d = MEASURE;
                    MEASURE: if (w_frame_ok && !w_bad_eval) w_state_d = LOCKED;
                    LOCKED: begin
                        if (w_bad_eval || !w_frame_ok) w_state_d = MEASURE;
                        if (w_bad_eval)                w_err_h_d = 1'b1;
                        if (!w_frame_ok)               w_err_v_d = 1'b1;
                    end
                    default: w_state_d = SEARCH;
                endcase
            end else begin
                w_l_cnt_d    = w_l_cnt_inc;
                w_bad_line_d = w_bad_eval;
            end
        end

        w_locked_d = (w_state_d == LOCKED);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_hs_prev_q    <= 1'b1;
            r_vs_prev_q    <= 1'b1;
            r_h_cnt_q      <= '0;
            r_hp_cnt_q     <= '0;
            r_l_cnt_q      <= '0;
            r_vp_cnt_q     <= '0;
            r_h_period_q   <= '0;
            r_h_pulse_q    <= '0;
            r_v_period_q   <= '0;
            r_v_pulse_q    <= '0;
            r_frame_cnt_q  <= '0;
            r_frame_done_q <= 1'b0;
            r_bad_line_q   <= 1'b0;
            r_locked_q     <= 1'b0;
            r_err_h_q      <= 1'b0;
            r_err_v_q      <= 1'b0;
            r_state_q      <= SEARCH;
        end else begin
            r_hs_prev_q    <= w_hs_prev_d;
            r_vs_prev_q    <= w_vs_prev_d;
            r_h_cnt_q      <= w_h_cnt_d;
            r_hp_cnt_q     <= w_hp_cnt_d;
            r_l_cnt_q      <= w_l_cnt_d;
            r_vp_cnt_q     <= w_vp_cnt_d;
            r_h_period_q   <= w_h_period_d;
            r_h_pulse_q    <= w_h_pulse_d;
            r_v_period_q   <= w_v_period_d;
            r_v_pulse_q    <= w_v_pulse_d;
            r_frame_cnt_q  <= w_frame_cnt_d;
            r_frame_done_q <= w_frame_done_d;
            r_bad_line_q   <= w_bad_line_d;
            r_locked_q     <= w_locked_d;
            r_err_h_q      <= w_err_h_d;
            r_err_v_q      <= w_err_v_d;
            r_state_q      <= w_state_d;
        end
    end

    assign h_period   = r_h_period_q;
    assign h_pulse    = r_h_pulse_q;
    assign v_period   = r_v_period_q;
    assign v_pulse    = r_v_pulse_q;
    assign frame_cnt  = r_frame_cnt_q;
    assign frame_done = r_frame_done_q;
    assign locked     = r_locked_q;
    assign err_h      = r_err_h_q;
    assign err_v      = r_err_v_q;

`ifdef VGA_MON_CRC_EN
    logic [15:0] r_crc_run_q, w_crc_run_d;
    logic [15:0] r_crc_q,     w_crc_d;
    logic [15:0] w_crc_next;

    // CRC-16-CCITT, poly 0x1021, MSB-first over one byte
    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign w_crc_next = crc_byte(r_crc_run_q, rgb);

    always_comb begin
        w_crc_run_d = r_crc_run_q;
        w_crc_d     = r_crc_q;
        if (pix_ce) begin
            if (w_v_fall) begin
                w_crc_d     = w_crc_next;
                w_crc_run_d = 16'hFFFF;
            end else begin
                w_crc_run_d = w_crc_next;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_crc_run_q <= 16'hFFFF;
            r_crc_q     <= '0;
        end else begin
            r_crc_run_q <= w_crc_run_d;
            r_crc_q     <= w_crc_d;
        end
    end

    assign crc = r_crc_q;
`else
    logic w_unused_rgb;
    assign w_unused_rgb = ^rgb;
    assign crc          = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_monitor
// Brief    : Directed bench for vga_frame_monitor on a reduced 20x12 raster,
//            checked every cycle against a tick-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_monitor;

    localparam int H   = 20;
    localparam int HS  = 4;
    localparam int V   = 12;
    localparam int VS  = 2;
    localparam int W   = 6;
    localparam int SAT = (1 << W) - 1;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         pix_ce = 1'b0;
    logic [7:0]   rgb    = 8'h00;
    logic         hsync  = 1'b1;
    logic         vsync  = 1'b1;
    logic [W-1:0] h_period, h_pulse, v_period, v_pulse;
    logic [15:0]  frame_cnt, crc;
    logic         frame_done, locked, err_h, err_v;

    vga_frame_monitor #(
        .H_TOTAL(H), .H_SYNC(HS), .V_TOTAL(V), .V_SYNC(VS), .CNT_W(W)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .h_period  (h_period),
        .h_pulse   (h_pulse),
        .v_period  (v_period),
        .v_pulse   (v_pulse),
        .frame_cnt (frame_cnt),
        .frame_done(frame_done),
        .locked    (locked),
        .err_h     (err_h),
        .err_v     (err_v),
        .crc       (crc)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;
    bit zero_px = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_zero_frame(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = crc_byte(c, 8'h00);
        return c;
    endfunction

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    // ---------------- behavioural model (tick-level, spec rules) ----------------
    int  m_tick, m_last_hfall, m_low, m_lines, m_vlines, m_state, m_per;
    bit  m_hs_prev, m_vs_prev, m_bad, m_crc_known, m_crc_valid;
    bit  m_hf, m_hr, m_vf, m_vr, m_bad_now, m_fok, m_lbad;
    int  e_h_period, e_h_pulse, e_v_period, e_v_pulse, e_frame_cnt;
    bit  e_frame_done, e_locked, e_err_h, e_err_v;
    logic [15:0] m_crc_run, e_crc;

    initial forever begin
        @(posedge clk_in or posedge rst);
        if (rst) begin
            m_tick = 0; m_last_hfall = 0; m_low = 0; m_lines = 0; m_vlines = 0;
            m_state = 0; m_hs_prev = 1'b1; m_vs_prev = 1'b1; m_bad = 1'b0;
            m_crc_known = 1'b0; m_crc_valid = 1'b0; m_crc_run = 16'hFFFF; e_crc = 16'h0;
            e_h_period = 0; e_h_pulse = 0; e_v_period = 0; e_v_pulse = 0; e_frame_cnt = 0;
            e_frame_done = 1'b0; e_locked = 1'b0; e_err_h = 1'b0; e_err_v = 1'b0;
        end else begin
            e_frame_done = 1'b0;
            if (pix_ce) begin
                m_hf = m_hs_prev && !hsync;
                m_hr = !m_hs_prev && hsync;
                m_vf = m_vs_prev && !vsync;
                m_vr = !m_vs_prev && vsync;
                m_bad_now = 1'b0;
                if (m_hf) begin
                    m_per = sat(m_tick - m_last_hfall);
                    e_h_period = m_per;
                    m_last_hfall = m_tick;
                    if (m_per != H) m_bad_now = 1'b1;
                    m_lines++;
                    if (!vsync) m_vlines++;
                end
                if (!hsync) m_low++;
                if (m_hr) begin
                    e_h_pulse = sat(m_low);
                    if (sat(m_low) != HS) m_bad_now = 1'b1;
                    m_low = 0;
                end
                if (m_vr) begin
                    e_v_pulse = sat(m_vlines);
                    m_vlines = 0;
                end
                if (m_vf) begin
                    m_fok = (sat(m_lines) == V) && (e_v_pulse == VS);
                    m_lbad = m_bad || m_bad_now;
                    e_v_period = sat(m_lines);
                    m_lines = 0;
                    e_frame_cnt = (e_frame_cnt + 1) % 65536;
                    e_frame_done = 1'b1;
                    if (m_state == 0) m_state = 1;
                    else if (m_state == 1) begin
                        if (m_fok && !m_lbad) m_state = 2;
                    end else if (!m_fok || m_lbad) begin
                        m_state = 1;
                        if (m_lbad) e_err_h = 1'b1;
                        if (!m_fok) e_err_v = 1'b1;
                    end
                    m_bad = 1'b0;
                    if (m_crc_known) m_crc_valid = 1'b1;
                    e_crc = crc_byte(m_crc_run, rgb);
                    m_crc_run = 16'hFFFF;
                    m_crc_known = 1'b1;
                end else begin
                    m_bad = m_bad || m_bad_now;
                    m_crc_run = crc_byte(m_crc_run, rgb);
                end
                m_hs_prev = hsync;
                m_vs_prev = vsync;
                m_tick++;
            end
            e_locked = (m_state == 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            chk("h_period",   int'(h_period),   e_h_period);
            chk("h_pulse",    int'(h_pulse),    e_h_pulse);
            chk("v_period",   int'(v_period),   e_v_period);
            chk("v_pulse",    int'(v_pulse),    e_v_pulse);
            chk("frame_cnt",  int'(frame_cnt),  e_frame_cnt);
            chk("frame_done", int'(frame_done), int'(e_frame_done));
            chk("locked",     int'(locked),     int'(e_locked));
            chk("err_h",      int'(err_h),      int'(e_err_h));
            chk("err_v",      int'(err_v),      int'(e_err_v));
`ifdef VGA_MON_CRC_EN
            if (m_crc_valid) chk("crc", int'(crc), int'(e_crc));
`else
            chk("crc", int'(crc), 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_tick(input logic hs, input logic vs, input logic [7:0] px);
        @(posedge clk_in); #1;
        pix_ce = 1'b1; hsync = hs; vsync = vs; rgb = px;
        @(posedge clk_in); #1;
        pix_ce = 1'b0;
        repeat (2) @(posedge clk_in);
    endtask

    task automatic send_cols(input int line, input int c0, input int c1, input int pulse);
        for (int c = c0; c <= c1; c++)
            drive_tick((c < pulse) ? 1'b0 : 1'b1, (line < VS) ? 1'b0 : 1'b1,
                       zero_px ? 8'h00 : 8'(line * 7 + c));
    endtask

    task automatic send_lines(input int l0, input int l1, input int long_line,
                              input int long_len, input int long_pulse);
        for (int l = l0; l <= l1; l++) begin
            if (l == long_line) send_cols(l, 0, long_len - 1, long_pulse);
            else                send_cols(l, 0, H - 1, HS);
        end
    endtask

    task automatic clean_frame();
        send_lines(0, V - 1, -1, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".h_period"},  int'(h_period),  0);
        chk({tag, ".h_pulse"},   int'(h_pulse),   0);
        chk({tag, ".v_period"},  int'(v_period),  0);
        chk({tag, ".v_pulse"},   int'(v_pulse),   0);
        chk({tag, ".frame_cnt"}, int'(frame_cnt), 0);
        chk({tag, ".locked"},    int'(locked),    0);
        chk({tag, ".err_h"},     int'(err_h),     0);
        chk({tag, ".err_v"},     int'(err_v),     0);
        chk({tag, ".crc"},       int'(crc),       0);
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk_all_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Partial frame: tail of line 5 plus lines 6..11
        send_cols(5, 10, H - 1, HS);
        send_lines(6, V - 1, -1, 0, 0);
        chk("partial.locked", int'(locked), 0);
        chk("partial.frame_cnt", int'(frame_cnt), 0);

        clean_frame();                                   // fall 1
        chk("f1.locked", int'(locked), 0);
        chk("f1.frame_cnt", int'(frame_cnt), 1);
        chk("f1.v_period", int'(v_period), 7);

        clean_frame();                                   // fall 2
        chk("f2.v_period", int'(v_period), 12);
        chk("f2.h_period", int'(h_period), 20);
        chk("f2.h_pulse",  int'(h_pulse), 4);
        chk("f2.v_pulse",  int'(v_pulse), 2);

        clean_frame();                                   // fall 3
        chk("f3.locked", int'(locked), 1);
        chk("f3.frame_cnt", int'(frame_cnt), 3);

        // Long pix_ce stall mid-frame
        send_lines(0, 5, -1, 0, 0);
        repeat (10000) @(posedge clk_in);
        send_lines(6, V - 1, -1, 0, 0);
        clean_frame();                                   // fall 5
        chk("stall.locked", int'(locked), 1);
        chk("stall.err_h", int'(err_h), 0);
        chk("stall.err_v", int'(err_v), 0);
        chk("stall.frame_cnt", int'(frame_cnt), 5);

        // Short frame (11 lines)
        send_lines(0, V - 2, -1, 0, 0);
        clean_frame();                                   // fall 7 judges it
        chk("short.err_v", int'(err_v), 1);
        chk("short.err_h", int'(err_h), 0);
        chk("short.v_period", int'(v_period), 11);
        chk("short.locked", int'(locked), 0);
        clean_frame();
        chk("short.relock", int'(locked), 1);

        // One line of 21 ticks
        send_lines(0, V - 1, 5, H + 1, HS);
        clean_frame();
        chk("long.err_h", int'(err_h), 1);
        chk("long.locked", int'(locked), 0);
        clean_frame();
        chk("long.relock", int'(locked), 1);
        chk("long.err_h_sticky", int'(err_h), 1);

        // Saturation: 100-tick line with an 80-tick hsync pulse
        send_lines(0, 5, 5, 100, 80);
        chk("sat.h_pulse", int'(h_pulse), SAT);
        send_cols(6, 0, 0, HS);
        chk("sat.h_period", int'(h_period), SAT);
        send_cols(6, 1, H - 1, HS);
        send_lines(7, V - 1, -1, 0, 0);

        // Asynchronous reset mid-line
        send_lines(0, 3, -1, 0, 0);
        send_cols(4, 0, 9, HS);
        @(posedge clk_in); #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk_in); #1;
        rst = 1'b0;
        send_cols(4, 10, H - 1, HS);
        send_lines(5, V - 1, -1, 0, 0);
        clean_frame();
        chk("rst.f1.locked", int'(locked), 0);
        clean_frame();
        clean_frame();
        chk("rst.f3.locked", int'(locked), 1);
        chk("rst.f3.frame_cnt", int'(frame_cnt), 3);
        chk("rst.f3.err_h", int'(err_h), 0);

        // Constant-zero rgb frames
        zero_px = 1'b1;
        clean_frame();
        clean_frame();
`ifdef VGA_MON_CRC_EN
        chk("crc.zero_frame_a", int'(crc), int'(crc_zero_frame(H * V)));
`else
        chk("crc.off_a", int'(crc), 0);
`endif
        clean_frame();
`ifdef VGA_MON_CRC_EN
        chk("crc.zero_frame_b", int'(crc), int'(crc_zero_frame(H * V)));
`else
        chk("crc.off_b", int'(crc), 0);
`endif
        zero_px = 1'b0;
        repeat (4) @(posedge clk_in);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
